// File: rtl/sram_byte_bridge_pkg.sv
// Shared types and frame-format constants for the byte-serial SRAM bridge.
// Contents: FSM state enum, opcode-byte field positions, frame lengths and
// small opcode decode helpers.
package sram_bridge_pkg;

  typedef enum logic [2:0] {
    OP,
    ADDR,
    WDATA,
    ISSUE,
    WAIT,
    RDATA
  } bridge_state_e;

  // Opcode byte: {rsvd[1:0], we, wmask[3:0], addr[8]}
  localparam int unsigned OP_WE_BIT      = 5;
  localparam int unsigned OP_MASK_LSB    = 1;
  localparam int unsigned OP_A8_BIT      = 0;
  localparam int unsigned OP_RSVD_MSB    = 7;
  localparam int unsigned OP_RSVD_LSB    = 6;
  localparam int unsigned FRAME_WR_BYTES = 6;
  localparam int unsigned FRAME_RD_BYTES = 2;
  localparam int unsigned WR_DATA_BYTES  = FRAME_WR_BYTES - FRAME_RD_BYTES;

  function automatic logic op_reserved(input logic [7:0] op);
    return op[OP_RSVD_MSB:OP_RSVD_LSB] != 2'b00;
  endfunction

  function automatic logic [3:0] op_mask(input logic [7:0] op);
    return op[OP_MASK_LSB +: 4];
  endfunction

endpackage

// File: rtl/sram_byte_bridge_if.sv
// Host-side byte stream bundle for the SRAM bridge.
//   in_valid/in_ready/in_data    : command frame bytes, host -> bridge
//   out_valid/out_ready/out_data : read data bytes, bridge -> host
// master = host side, slave = bridge side.
interface sram_byte_bridge_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sram_byte_bridge_ser.sv
// 32-bit load / byte shift-out register with valid/ready, LSB byte first.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_load     : load i_word and start presenting byte 0
//   i_word     : word to serialise
//   o_valid    : o_data holds a byte not yet taken
//   i_ready    : consumer takes o_data when o_valid && i_ready
//   o_data     : current byte (held stable while stalled)
//   o_last     : current byte is byte 3
module sram_byte_ser (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [31:0] i_word,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [7:0]  o_data,
  output logic        o_last
);

  logic [31:0] r_word;
  logic [1:0]  r_cnt;
  logic        r_valid;
  logic        w_fire;

  assign w_fire  = r_valid && i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_word[7:0];
  assign o_last  = (r_cnt == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word  <= '0;
      r_cnt   <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_cnt   <= '0;
      r_valid <= 1'b1;
    end else if (w_fire) begin
      r_word <= {8'h00, r_word[31:8]};
      r_cnt  <= r_cnt + 2'd1;
      if (r_cnt == 2'd3) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sram_byte_bridge.sv
// Byte-serial host front end for a 32x512 SRAM macro (read/write port 0).
// Collects a 2-byte read or 6-byte write frame, issues one macro access with
// registered controls, and streams read words back as 4 bytes, LSB first.
// Ports:
//   clk, rst_n     : clock (also the macro clock), async active-low reset
//   host           : byte stream bundle (slave side)
//   o_busy         : high whenever the FSM is not in OP
//   o_sram_csb0    : chip select, active low, low only during ISSUE
//   o_sram_web0    : write enable, active low
//   o_sram_wmask0  : byte write mask
//   o_sram_addr0   : word address
//   o_sram_din0    : write data
//   i_sram_dout0   : read data from the macro
module sram_byte_bridge
  import sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,  // fixed by the frame format
  parameter int unsigned RD_LAT = 1   // 1..3
) (
  input  logic                clk,
  input  logic                rst_n,
  sram_byte_bridge_if.slave   host,
  output logic                o_busy,
  output logic                o_sram_csb0,
  output logic                o_sram_web0,
  output logic [3:0]          o_sram_wmask0,
  output logic [ADDR_W-1:0]   o_sram_addr0,
  output logic [31:0]         o_sram_din0,
  input  logic [31:0]         i_sram_dout0
);

  bridge_state_e r_state, w_state_nxt;

  logic [7:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [23:0]       r_din;
  logic [1:0]        r_cnt;
  logic [1:0]        r_lat;
  logic [31:0]       r_hold;
  logic              r_ser_loaded;
  logic              r_in_ready;

  logic              r_csb0;
  logic              r_web0;
  logic [3:0]        r_wmask0;
  logic [ADDR_W-1:0] r_addr0;
  logic [31:0]       r_din0;

  logic              w_in_fire;
  logic              w_we;
  logic              w_issue;
  logic              w_in_ready_nxt;
  logic              w_ser_load;
  logic              w_ser_valid;
  logic              w_ser_last;
  logic              w_ser_done;
  logic [7:0]        w_ser_data;
  logic [ADDR_W-1:0] w_addr_full;

  assign w_in_fire   = host.in_valid && r_in_ready;
  assign w_we        = r_op[OP_WE_BIT];
  assign w_addr_full = {r_op[OP_A8_BIT], host.in_data};
  assign w_ser_done  = w_ser_valid && host.out_ready && w_ser_last;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= OP;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      OP: begin
        if (w_in_fire) w_state_nxt = ADDR;
      end
      ADDR: begin
        if (w_in_fire) begin
          if (op_reserved(r_op)) w_state_nxt = OP;
          else if (w_we)         w_state_nxt = WDATA;
          else                   w_state_nxt = ISSUE;
        end
      end
      WDATA: begin
        if (w_in_fire && (r_cnt == 2'(WR_DATA_BYTES - 1))) w_state_nxt = ISSUE;
      end
      ISSUE: begin
        w_state_nxt = w_we ? OP : WAIT;
      end
      WAIT: begin
        if (r_lat == 2'(RD_LAT - 1)) w_state_nxt = RDATA;
      end
      RDATA: begin
        if (w_ser_done) w_state_nxt = OP;
      end
      default: w_state_nxt = OP;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy         = (r_state != OP);
    w_issue        = (w_state_nxt == ISSUE);
    w_in_ready_nxt = (w_state_nxt == OP) || (w_state_nxt == ADDR) || (w_state_nxt == WDATA);
    // Serializer loads from the holding register on the first RDATA cycle.
    w_ser_load     = (r_state == RDATA) && !r_ser_loaded;
  end

  // Frame deserializer, latency counter and read holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op         <= '0;
      r_addr       <= '0;
      r_din        <= '0;
      r_cnt        <= '0;
      r_lat        <= '0;
      r_hold       <= '0;
      r_ser_loaded <= 1'b0;
      r_in_ready   <= 1'b0;
    end else begin
      // Registered from next state so it is already correct in the first cycle of each state.
      r_in_ready <= w_in_ready_nxt;

      if (w_in_fire) begin
        unique case (r_state)
          OP: r_op <= host.in_data;
          ADDR: begin
            r_addr <= w_addr_full;
            r_cnt  <= '0;
          end
          WDATA: begin
            unique case (r_cnt)
              2'd0:    r_din[7:0]   <= host.in_data;
              2'd1:    r_din[15:8]  <= host.in_data;
              2'd2:    r_din[23:16] <= host.in_data;
              default: ;  // byte 3 goes straight to the din0 register
            endcase
            r_cnt <= r_cnt + 2'd1;
          end
          default: ;
        endcase
      end

      if (r_state == WAIT) r_lat <= r_lat + 2'd1;
      else                 r_lat <= '0;

      if ((r_state == WAIT) && (w_state_nxt == RDATA)) begin
        r_hold <= i_sram_dout0;
      end

      r_ser_loaded <= (w_state_nxt == RDATA) && (r_ser_loaded || w_ser_load);
    end
  end

  // SRAM port registers: loaded on the edge entering ISSUE, held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_csb0   <= 1'b1;
      r_web0   <= 1'b1;
      r_wmask0 <= '0;
      r_addr0  <= '0;
      r_din0   <= '0;
    end else begin
      r_csb0 <= !w_issue;
      if (w_issue) begin
        r_web0   <= !w_we;
        r_wmask0 <= w_we ? op_mask(r_op) : 4'h0;
        // A read enters ISSUE straight from ADDR, so the low address byte is still on the bus.
        r_addr0  <= (r_state == ADDR) ? w_addr_full : r_addr;
        if (w_we) begin
          r_din0 <= {host.in_data, r_din};
        end
      end
    end
  end

  assign o_sram_csb0   = r_csb0;
  assign o_sram_web0   = r_web0;
  assign o_sram_wmask0 = r_wmask0;
  assign o_sram_addr0  = r_addr0;
  assign o_sram_din0   = r_din0;

  sram_byte_ser u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_ser_load),
    .i_word  (r_hold),
    .o_valid (w_ser_valid),
    .i_ready (host.out_ready),
    .o_data  (w_ser_data),
    .o_last  (w_ser_last)
  );

  assign host.in_ready  = r_in_ready;
  assign host.out_valid = w_ser_valid;
  assign host.out_data  = w_ser_data;

endmodule

// File: tb/tb_sram_byte_bridge.sv
// Directed self-checking bench for sram_byte_bridge with a behavioural
// RD_LAT=1 SRAM macro model.
module tb_sram_byte_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy, csb0, web0;
  logic [3:0]  wmask0;
  logic [8:0]  addr0;
  logic [31:0] din0;
  logic [31:0] dout0 = '0;

  always #5 clk = ~clk;

  sram_byte_bridge_if host_if ();

  sram_byte_bridge #(
    .ADDR_W (9),
    .RD_LAT (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .host          (host_if),
    .o_busy        (busy),
    .o_sram_csb0   (csb0),
    .o_sram_web0   (web0),
    .o_sram_wmask0 (wmask0),
    .o_sram_addr0  (addr0),
    .o_sram_din0   (din0),
    .i_sram_dout0  (dout0)
  );

  // Macro model: samples controls at the clock edge, dout valid one cycle later.
  logic [31:0] mem [512];
  initial for (int i = 0; i < 512; i++) mem[i] = '0;

  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask0[b]) mem[addr0][8*b +: 8] <= din0[8*b +: 8];
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Access monitor: one count per cycle with csb0 low.
  int          n_acc = 0;
  logic        acc_web;
  logic [3:0]  acc_mask;
  logic [8:0]  acc_addr;
  logic [31:0] acc_din;
  always @(negedge clk) begin
    if (!csb0) begin
      n_acc    = n_acc + 1;
      acc_web  = web0;
      acc_mask = wmask0;
      acc_addr = addr0;
      acc_din  = din0;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int edge_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called and returns at a negedge; edge_cyc = index of the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    host_if.in_valid = 1'b1;
    host_if.in_data  = b;
    while (!host_if.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!host_if.in_ready) begin
      check_eq("send_ready", host_if.in_ready, 1);
      host_if.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    edge_cyc = cyc;
    host_if.in_valid = 1'b0;
  endtask

  task automatic write_word(input logic [8:0] a, input logic [3:0] m, input logic [31:0] d);
    send_byte({2'b00, 1'b1, m, a[8]});
    send_byte(a[7:0]);
    for (int k = 0; k < 4; k++) send_byte(d[8*k +: 8]);
  endtask

  // Reads a word; byte 0 is held off for `stall` cycles with stability checks.
  task automatic read_word(input logic [8:0] a, input int stall,
                           output logic [31:0] w, output int lat);
    logic [7:0] b;
    int t;
    w   = '0;
    lat = -1;
    send_byte({7'b0000000, a[8]});
    send_byte(a[7:0]);
    for (int k = 0; k < 4; k++) begin
      t = 0;
      while (!host_if.out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!host_if.out_valid) begin
        check_eq("rd_valid", host_if.out_valid, 1);
        return;
      end
      if (k == 0) lat = cyc - edge_cyc;
      b = host_if.out_data;
      if (k == 0) begin
        for (int s = 0; s < stall; s++) begin
          @(negedge clk);
          check_eq("stall_valid", host_if.out_valid, 1);
          check_eq("stall_data", host_if.out_data, b);
        end
      end
      host_if.out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      host_if.out_ready = 1'b0;
      w[8*k +: 8] = b;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    int lat;
    int acc0;

    host_if.in_valid  = 1'b0;
    host_if.in_data   = '0;
    host_if.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_in_ready", host_if.in_ready, 0);
    check_eq("rst_out_valid", host_if.out_valid, 0);
    check_eq("rst_out_data", host_if.out_data, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_csb0", csb0, 1);
    check_eq("rst_web0", web0, 1);
    check_eq("rst_wmask0", wmask0, 0);
    check_eq("rst_addr0", addr0, 0);
    check_eq("rst_din0", din0, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("op_in_ready", host_if.in_ready, 1);

    // Full write to 0x1FF
    acc0 = n_acc;
    write_word(9'h1FF, 4'hF, 32'h44332211);
    check_eq("issue_csb0", csb0, 0);
    check_eq("issue_busy", busy, 1);
    check_eq("issue_in_ready", host_if.in_ready, 0);
    @(negedge clk);
    check_eq("post_csb0", csb0, 1);
    check_eq("post_busy", busy, 0);
    check_eq("post_in_ready", host_if.in_ready, 1);
    check_eq("wr_acc_cnt", n_acc - acc0, 1);
    check_eq("wr_web0", acc_web, 0);
    check_eq("wr_wmask0", acc_mask, 4'hF);
    check_eq("wr_addr0", acc_addr, 9'h1FF);
    check_eq("wr_din0", acc_din, 32'h44332211);

    // Read back 0x1FF
    acc0 = n_acc;
    read_word(9'h1FF, 0, w, lat);
    check_eq("rd_data", w, 32'h44332211);
    check_eq("rd_latency", lat, 3);
    check_eq("rd_acc_cnt", n_acc - acc0, 1);
    check_eq("rd_web0", acc_web, 1);
    check_eq("rd_wmask0", acc_mask, 4'h0);
    check_eq("rd_addr0", acc_addr, 9'h1FF);

    // Masked write over a known word at 0x110
    write_word(9'h110, 4'hF, 32'h44332211);
    write_word(9'h110, 4'h2, 32'hDDCCBBAA);
    @(negedge clk);
    check_eq("mw_wmask0", acc_mask, 4'h2);
    check_eq("mw_din0", acc_din, 32'hDDCCBBAA);
    check_eq("mw_addr0", acc_addr, 9'h110);
    read_word(9'h110, 0, w, lat);
    check_eq("mw_rd_data", w, 32'h4433BB11);

    // Back-pressure on the first read byte
    read_word(9'h110, 5, w, lat);
    check_eq("stall_rd_data", w, 32'h4433BB11);
    check_eq("stall_rd_done", host_if.out_valid, 0);

    // Reserved opcode is dropped
    acc0 = n_acc;
    send_byte(8'hC0);
    send_byte(8'h05);
    repeat (3) @(negedge clk);
    check_eq("rsvd_busy", busy, 0);
    check_eq("rsvd_acc_cnt", n_acc - acc0, 0);
    read_word(9'h1FF, 0, w, lat);
    check_eq("rsvd_next_rd", w, 32'h44332211);

    // Reset in the middle of a write frame
    acc0 = n_acc;
    send_byte(8'h3F);
    send_byte(8'hFF);
    send_byte(8'h55);
    send_byte(8'h66);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_csb0", csb0, 1);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_in_ready", host_if.in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("mid_rst_acc_cnt", n_acc - acc0, 0);
    read_word(9'h1FF, 0, w, lat);
    check_eq("mid_rst_rd_data", w, 32'h44332211);
    check_eq("mid_rst_rd_lat", lat, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
